pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage MIPS pipeline.
- Detects load-use hazards and hazards on branches resolved in ID.
- Sequences the multi-cycle HI/LO multiply/divide unit and holds dependent instructions until HI/LO is valid.
- Drives the PC/IF-ID write enables and the IF-ID/ID-EX flush controls.
- Sits beside EXForward: EXForward covers every hazard that can be forwarded; this block covers the rest.

Parameters:
MUL_LAT, 4, cycles from mult/multu start to HI/LO valid (min 1)
DIV_LAT, 32, cycles from div/divu start to HI/LO valid (min 1)
CW, 6, width of the multiply/divide cycle counter (must hold max(MUL_LAT, DIV_LAT))

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
ID_Rs  in  5  rs field of the instruction in ID
ID_Rt  in  5  rt field of the instruction in ID
ID_UseRt  in  1  instruction in ID reads rt
ID_Branch  in  1  instruction in ID is a conditional branch (operands compared in ID)
ID_BranchTaken  in  1  branch comparison result in ID
ID_Jump  in  1  j/jal/jr/jalr in ID
ID_UseHILO  in  1  mfhi/mflo/mthi/mtlo in ID
ID_MDStart  in  1  mult/multu/div/divu in ID
ID_MDIsDiv  in  1  the multiply/divide op in ID is a divide
ID_EX_MemRead  in  1  load in EX
ID_EX_RegWrite  in  1  instruction in EX writes the register file
ID_EX_Write_register  in  5  destination register of the instruction in EX
EX_DM_MemRead  in  1  load in DM
EX_DM_Write_register  in  5  destination register of the instruction in DM
PC_Write  out  1  PC update enable
IF_ID_Write  out  1  IF/ID register enable
IF_ID_Flush  out  1  load a NOP into IF/ID
ID_EX_Flush  out  1  insert a bubble into ID/EX
MD_Start  out  1  one-cycle start pulse to the multiply/divide unit
MD_Busy  out  1  multiply/divide operation in flight
MD_Done  out  1  one-cycle pulse when HI/LO becomes valid

Behaviour:
- Register matching:
  - Rs match: register != 0 and equal to ID_Rs.
  - Rt match: register != 0, equal to ID_Rt, and ID_UseRt = 1.
- Hazard terms, all combinational in the current cycle:
  - load_use: ID_EX_MemRead and (Rs or Rt match on ID_EX_Write_register).
  - br_ex: ID_Branch and ID_EX_RegWrite and match on ID_EX_Write_register.
  - br_dm: ID_Branch and EX_DM_MemRead and match on EX_DM_Write_register.
  - md_hold: state is BUSY and (ID_UseHILO or ID_MDStart).
- stall = load_use | br_ex | br_dm | md_hold.
- A load followed by a dependent branch stalls 2 cycles: br_ex in the first cycle, br_dm in the second. No extra state is used.
- When stall = 1:
  - PC_Write = 0, IF_ID_Write = 0, ID_EX_Flush = 1.
  - IF_ID_Flush = 0.
  - MD_Start = 0.
  - Branch/jump redirect is ignored this cycle.
- When stall = 0:
  - PC_Write = IF_ID_Write = 1, ID_EX_Flush = 0.
  - IF_ID_Flush = (ID_Branch & ID_BranchTaken) | ID_Jump.
- Multiply/divide FSM (registered):
  - States: IDLE, BUSY.
  - IDLE -> BUSY when ID_MDStart & ~stall.
    - That cycle: MD_Start = 1.
    - Counter loads DIV_LAT-1 if ID_MDIsDiv, else MUL_LAT-1.
  - BUSY: counter decrements each cycle. When the counter = 0, go to IDLE and assert MD_Done for that one cycle.
  - MD_Busy = (state == BUSY).
  - In BUSY, a new ID_MDStart is held by md_hold. Its MD_Start fires in the first IDLE cycle after MD_Done. Back-to-back operations therefore lose exactly one cycle.
  - LAT = 1: BUSY lasts one cycle, and MD_Done fires the cycle after MD_Start.
- Simultaneous events:
  - A branch/jump that is stalled is flushed only once its stall clears.
  - A branch/jump and ID_MDStart cannot both be asserted (same instruction slot). If they are, the flush takes effect and MD_Start still fires when there is no stall.
- Reset:
  - reset low at any time forces state IDLE and counter 0 immediately.
  - An in-flight multiply/divide is abandoned and MD_Done is not pulsed.
  - Outputs during reset: MD_Busy = 0, MD_Start = 0, MD_Done = 0, ID_EX_Flush = 0, IF_ID_Flush = 0, PC_Write = 1, IF_ID_Write = 1.
  - After reset releases, the combinational outputs follow the inputs normally.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined:
  - Adds two 32-bit output ports: Stall_Cycles and Flush_Count.
  - Stall_Cycles increments on every cycle with stall = 1.
  - Flush_Count increments on every cycle with IF_ID_Flush = 1.
  - Both wrap at 2^32 and clear to 0 on reset.
- Undefined: the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- lw $5 in EX (ID_EX_MemRead=1, ID_EX_Write_register=5); ID has ID_Rs=5 -> exactly 1 cycle: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle all clear.
- lw $8, then beq $8,$9 in ID -> cycle 1 br_ex stall, cycle 2 br_dm stall, cycle 3 no stall and IF_ID_Flush=1 when ID_BranchTaken=1.
- ID_MDStart with ID_MDIsDiv=1, DIV_LAT=32 -> MD_Start pulses once, MD_Busy high 32 cycles, MD_Done pulses 32 cycles after MD_Start; a mflo arriving in ID meanwhile is stalled until MD_Done and proceeds the cycle after.
- Two mult in a row, MUL_LAT=4 -> second MD_Start exactly 5 cycles after the first.
- reset pulled low mid-divide (counter=10) -> MD_Busy=0 at once, no MD_Done pulse; the next divide after release runs the full 32 cycles.
- ID_Rt=0 with ID_EX_Write_register=0 and load in EX -> no stall (register zero excluded); ID_UseRt=0 with an rt match -> no stall.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - ID/EX/DM hazard inputs and stall/flush/mul-div outputs of the hazard controller
interface pipeline_hazard_ctrl_if;
    logic [4:0] ID_Rs;
    logic [4:0] ID_Rt;
    logic       ID_UseRt;
    logic       ID_Branch;
    logic       ID_BranchTaken;
    logic       ID_Jump;
    logic       ID_UseHILO;
    logic       ID_MDStart;
    logic       ID_MDIsDiv;
    logic       ID_EX_MemRead;
    logic       ID_EX_RegWrite;
    logic [4:0] ID_EX_Write_register;
    logic       EX_DM_MemRead;
    logic [4:0] EX_DM_Write_register;
    logic       PC_Write;
    logic       IF_ID_Write;
    logic       IF_ID_Flush;
    logic       ID_EX_Flush;
    logic       MD_Start;
    logic       MD_Busy;
    logic       MD_Done;

    modport master (
        output ID_Rs, ID_Rt, ID_UseRt, ID_Branch, ID_BranchTaken, ID_Jump,
               ID_UseHILO, ID_MDStart, ID_MDIsDiv, ID_EX_MemRead, ID_EX_RegWrite,
               ID_EX_Write_register, EX_DM_MemRead, EX_DM_Write_register,
        input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Start, MD_Busy, MD_Done
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UseRt, ID_Branch, ID_BranchTaken, ID_Jump,
               ID_UseHILO, ID_MDStart, ID_MDIsDiv, ID_EX_MemRead, ID_EX_RegWrite,
               ID_EX_Write_register, EX_DM_MemRead, EX_DM_Write_register,
        output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Start, MD_Busy, MD_Done
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - MIPS stall/flush scheduler and HI/LO mul-div sequencer
// Optional HAZARD_PERF_CNT_EN adds Stall_Cycles / Flush_Count counters.
module pipeline_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CW      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           Stall_Cycles,
    output logic [31:0]           Flush_Count
`endif
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

    md_state_t     state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    logic rs_ex, rt_ex, rs_dm, rt_dm;
    logic load_use, br_ex, br_dm, md_hold, stall;
    logic redirect, md_start, md_done;

    assign rs_ex = (hz.ID_EX_Write_register != 5'd0) && (hz.ID_EX_Write_register == hz.ID_Rs);
    assign rt_ex = (hz.ID_EX_Write_register != 5'd0) && (hz.ID_EX_Write_register == hz.ID_Rt) && hz.ID_UseRt;
    assign rs_dm = (hz.EX_DM_Write_register != 5'd0) && (hz.EX_DM_Write_register == hz.ID_Rs);
    assign rt_dm = (hz.EX_DM_Write_register != 5'd0) && (hz.EX_DM_Write_register == hz.ID_Rt) && hz.ID_UseRt;

    // Load followed by a dependent branch falls out as br_ex then br_dm, two stall cycles with no extra state.
    assign load_use = hz.ID_EX_MemRead && (rs_ex || rt_ex);
    assign br_ex    = hz.ID_Branch && hz.ID_EX_RegWrite && (rs_ex || rt_ex);
    assign br_dm    = hz.ID_Branch && hz.EX_DM_MemRead && (rs_dm || rt_dm);
    assign md_hold  = (state_q == BUSY) && (hz.ID_UseHILO || hz.ID_MDStart);
    assign stall    = reset && (load_use || br_ex || br_dm || md_hold);
    assign redirect = reset && !stall && ((hz.ID_Branch && hz.ID_BranchTaken) || hz.ID_Jump);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        md_start = 1'b0;
        md_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (reset && hz.ID_MDStart && !stall) begin
                    md_start = 1'b1;
                    state_d  = BUSY;
                    count_d  = hz.ID_MDIsDiv ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                if (count_q == '0) begin
                    md_done = 1'b1;
                    state_d = IDLE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign hz.PC_Write    = !stall;
    assign hz.IF_ID_Write = !stall;
    assign hz.ID_EX_Flush = stall;
    assign hz.IF_ID_Flush = redirect;
    assign hz.MD_Start    = md_start;
    assign hz.MD_Busy     = (state_q == BUSY);
    assign hz.MD_Done     = md_done;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Stall_Cycles <= '0;
            Flush_Count  <= '0;
        end else begin
            if (stall)    Stall_Cycles <= Stall_Cycles + 32'd1;
            if (redirect) Flush_Count  <= Flush_Count + 32'd1;
        end
    end
`endif
endmodule
